// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the sequence checker it feeds.
// Both ends take the target sequence from here so they agree on it.
package seq_pkg;

    localparam int unsigned PAT_W_DEF = 16;
    localparam int unsigned LEN_W_DEF = 5;
    localparam int unsigned CNT_W_DEF = 4;

    // Target sequence the downstream checker looks for.
    localparam int unsigned          CHK_LEN     = 4;
    localparam logic [CHK_LEN-1:0]   CHK_PATTERN = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable left shift register. On load the pattern is aligned so bit [len-1]
// lands in the top bit; msb_o is a direct flop tap and reads 0 once len bits are out.
module seq_gen_shreg #(
    parameter int unsigned PAT_W = 16,
    parameter int unsigned LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [PAT_W-1:0] data_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             msb_o
);

    logic [PAT_W-1:0] sr_q;
    logic [PAT_W-1:0] sr_d;
    logic [LEN_W-1:0] align;

    always_comb begin
        align = LEN_W'(PAT_W) - len_i;
        sr_d  = sr_q;
        if (clear_i) begin
            sr_d = '0;
        end else if (load_i) begin
            sr_d = data_i << align;
        end else if (shift_i) begin
            sr_d = sr_q << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[PAT_W-1];

endmodule

// File: rtl/seq_gen.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first with
// repeat count, optional inter-repetition gap and abort.
module seq_gen
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W   = PAT_W_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned GAP_CYC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] rep,
    output logic             data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam bit          HAS_GAP  = (GAP_CYC != 0);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sr_clear, sr_load, sr_shift, sr_sel_new;
    logic [LEN_W-1:0] len_c;
    logic             accept, last_bit, last_rep, gap_last;

    // Out-of-range lengths transmit the full register width.
    assign len_c    = (len == '0 || len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    assign accept   = start && !stop;
    assign last_bit = (bit_cnt_q == len_q - LEN_W'(1));
    assign last_rep = (rep_q == CNT_W'(1));
    assign gap_last = (gap_cnt_q == GAP_W'(GAP_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            rep_q     <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            rep_q     <= rep_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (last_bit) begin
                    if (last_rep)     state_d = ST_IDLE;
                    else if (HAS_GAP) state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (stop)          state_d = ST_IDLE;
                else if (gap_last) state_d = ST_SHIFT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rep_q == 0 means repeat forever, so it is never decremented from zero.
    always_comb begin
        pat_d      = pat_q;
        len_d      = len_q;
        rep_d      = rep_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        done_d     = 1'b0;
        sr_clear   = 1'b0;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_sel_new = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pat_d      = pattern;
                    len_d      = len_c;
                    rep_d      = rep;
                    bit_cnt_d  = '0;
                    sr_load    = 1'b1;
                    sr_sel_new = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (stop) begin
                    sr_clear  = 1'b1;
                    bit_cnt_d = '0;
                end else if (last_bit) begin
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    if (rep_q != '0) rep_d = rep_q - CNT_W'(1);
                    if (last_rep) begin
                        sr_shift = 1'b1;
                        done_d   = 1'b1;
                    end else if (HAS_GAP) begin
                        sr_shift = 1'b1;
                    end else begin
                        sr_load = 1'b1;
                    end
                end else begin
                    sr_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q + LEN_W'(1);
                end
            end
            ST_GAP: begin
                if (stop) begin
                    sr_clear  = 1'b1;
                    gap_cnt_d = '0;
                end else if (gap_last) begin
                    sr_load   = 1'b1;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: sr_clear = 1'b1;
        endcase
        valid_d = (state_d == ST_SHIFT);
        busy_d  = (state_d != ST_IDLE);
    end

    seq_gen_shreg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (sr_clear),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (sr_sel_new ? pattern : pat_q),
        .len_i   (sr_sel_new ? len_c : len_q),
        .msb_o   (data_out)
    );

    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: two instances (no gap / 2-cycle gap) checked every cycle
// against a timeline model, plus a vector table and directed corner sequences.
module tb_seq_gen;

    localparam int PAT_W = 16;
    localparam int LEN_W = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] rep;
    logic [1:0]       dout, dval, dbusy, ddone;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_gen #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_CYC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pattern(pattern),
        .len(len), .rep(rep), .data_out(dout[0]), .data_valid(dval[0]),
        .busy(dbusy[0]), .done(ddone[0]));

    seq_gen #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_CYC(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pattern(pattern),
        .len(len), .rep(rep), .data_out(dout[1]), .data_valid(dval[1]),
        .busy(dbusy[1]), .done(ddone[1]));

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Timeline model: a job is a position t since acceptance; every output
    // follows from t, the pattern length and the gap by plain arithmetic.
    bit         act_m  [2];
    bit         done_m [2];
    int         t_m    [2];
    int         len_m  [2];
    int         rep_m  [2];
    logic [15:0] pat_m [2];

    function automatic int gap_of(input int m);
        return (m == 0) ? 0 : 2;
    endfunction

    function automatic int clamp_len(input logic [LEN_W-1:0] l);
        return (l == 0 || int'(l) > PAT_W) ? PAT_W : int'(l);
    endfunction

    function automatic int job_cycles(input int m);
        return rep_m[m] * len_m[m] + (rep_m[m] - 1) * gap_of(m);
    endfunction

    function automatic logic [3:0] model_exp(input int m);
        int   o;
        logic v, b;
        v = 1'b0;
        b = 1'b0;
        if (act_m[m]) begin
            o = t_m[m] % (len_m[m] + gap_of(m));
            if (o < len_m[m]) begin
                v = 1'b1;
                b = pat_m[m][len_m[m] - 1 - o];
            end
        end
        return {b, v, act_m[m], done_m[m]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                act_m[m]  <= 1'b0;
                done_m[m] <= 1'b0;
                t_m[m]    <= 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                done_m[m] <= 1'b0;
                if (act_m[m]) begin
                    if (stop) begin
                        act_m[m] <= 1'b0;
                    end else if (rep_m[m] != 0 && t_m[m] + 1 == job_cycles(m)) begin
                        act_m[m]  <= 1'b0;
                        done_m[m] <= 1'b1;
                    end else begin
                        t_m[m] <= t_m[m] + 1;
                    end
                end else if (start && !stop) begin
                    act_m[m] <= 1'b1;
                    t_m[m]   <= 0;
                    pat_m[m] <= pattern;
                    len_m[m] <= clamp_len(len);
                    rep_m[m] <= int'(rep);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int m = 0; m < 2; m++) begin
                cmp($sformatf("model_dut%0d {out,valid,busy,done}", m),
                    {dout[m], dval[m], dbusy[m], ddone[m]}, model_exp(m));
            end
        end
    end

    typedef struct {
        logic             start;
        logic             stop;
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic [CNT_W-1:0] rep;
        logic [3:0]       exp;   // {data_out, data_valid, busy, done} after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic p, input logic [PAT_W-1:0] pt,
                       input logic [LEN_W-1:0] l, input logic [CNT_W-1:0] r,
                       input logic [3:0] e);
        vec_t v;
        v.start = s; v.stop = p; v.pat = pt; v.len = l; v.rep = r; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        start = 1'b0; stop = 1'b0;
    endtask

    logic [15:0] bits;
    logic [15:0] vals;
    int          dn0, dn1, vcnt;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        pattern = '0; len = '0; rep = '0;
        #20 rst_n = 1'b1;
        @(negedge clk);
        cmp("reset dut0 outputs", {dout[0], dval[0], dbusy[0], ddone[0]}, 4'b0000);
        cmp("reset dut2 outputs", {dout[1], dval[1], dbusy[1], ddone[1]}, 4'b0000);

        // single shot, back-to-back repeat with ignored inputs, restart on done, start+stop
        add(1, 0, 16'h000B, 4, 1, 4'b1110);
        add(0, 0, 16'h000B, 4, 1, 4'b0110);
        add(0, 0, 16'h000B, 4, 1, 4'b1110);
        add(0, 0, 16'h000B, 4, 1, 4'b1110);
        add(0, 0, 16'h000B, 4, 1, 4'b0001);
        add(0, 0, 16'h000B, 4, 1, 4'b0000);
        add(1, 0, 16'hABCB, 4, 2, 4'b1110);
        add(0, 0, 16'hFFFF, 9, 5, 4'b0110);
        add(1, 0, 16'h0000, 2, 1, 4'b1110);
        add(0, 0, 16'h0000, 2, 1, 4'b1110);
        add(0, 0, 16'h0000, 2, 1, 4'b1110);
        add(0, 0, 16'h0000, 2, 1, 4'b0110);
        add(0, 0, 16'h0000, 2, 1, 4'b1110);
        add(0, 0, 16'h0000, 2, 1, 4'b1110);
        add(0, 0, 16'h0000, 2, 1, 4'b0001);
        add(1, 0, 16'h000B, 4, 1, 4'b1110);
        add(0, 0, 16'h000B, 4, 1, 4'b0110);
        add(0, 0, 16'h000B, 4, 1, 4'b1110);
        add(0, 0, 16'h000B, 4, 1, 4'b1110);
        add(0, 0, 16'h000B, 4, 1, 4'b0001);
        add(1, 1, 16'h000B, 4, 1, 4'b0000);
        add(0, 1, 16'h000B, 4, 1, 4'b0000);
        add(0, 0, 16'h000B, 4, 1, 4'b0000);

        foreach (vecs[i]) begin
            start = vecs[i].start; stop = vecs[i].stop;
            pattern = vecs[i].pat; len = vecs[i].len; rep = vecs[i].rep;
            @(negedge clk);
            cmp($sformatf("vec%0d dut0 {out,valid,busy,done}", i),
                {dout[0], dval[0], dbusy[0], ddone[0]}, vecs[i].exp);
        end
        drive_idle();
        repeat (15) @(negedge clk);

        // gap of 2 between three repetitions of 110
        start = 1'b1; pattern = 16'h0006; len = 3; rep = 3;
        bits = '0; vals = '0; dn1 = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c < 13) begin
                bits = {bits[14:0], dout[1]};
                vals = {vals[14:0], dval[1]};
            end
            dn1 += int'(ddone[1]);
        end
        cmp("gap stream data", bits[12:0], 13'b1100011000110);
        cmp("gap stream valid", vals[12:0], 13'b1110011100111);
        cmp("gap done pulses", dn1, 1);
        repeat (5) @(negedge clk);

        // len=0 sends the full width
        start = 1'b1; pattern = 16'hC3A5; len = 0; rep = 1;
        bits = '0; vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (dval[0]) begin
                bits = {bits[14:0], dout[0]};
                vcnt++;
            end
        end
        cmp("len0 bit count", vcnt, 16);
        cmp("len0 bits", bits, 16'hC3A5);
        repeat (5) @(negedge clk);

        // infinite repetition aborted after six bits
        start = 1'b1; pattern = 16'h000B; len = 4; rep = 0;
        bits = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            bits = {bits[14:0], dout[0]};
        end
        cmp("infinite first six bits", bits[5:0], 6'b101110);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        cmp("abort dut0 outputs", {dout[0], dval[0], dbusy[0], ddone[0]}, 4'b0000);
        cmp("abort dut2 outputs", {dout[1], dval[1], dbusy[1], ddone[1]}, 4'b0000);
        dn0 = 0; dn1 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            dn0 += int'(ddone[0]);
            dn1 += int'(ddone[1]);
        end
        cmp("abort done dut0", dn0, 0);
        cmp("abort done dut2", dn1, 0);

        // asynchronous reset in the middle of a transmission
        start = 1'b1; pattern = 16'h00F0; len = 8; rep = 0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("midreset dut0 outputs", {dout[0], dval[0], dbusy[0], ddone[0]}, 4'b0000);
        cmp("midreset dut2 outputs", {dout[1], dval[1], dbusy[1], ddone[1]}, 4'b0000);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cmp("post reset dut0 done", ddone[0], 1'b0);
        cmp("post reset dut2 busy", dbusy[1], 1'b0);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 3) == 0);
            stop    = ($urandom_range(0, 49) == 0);
            pattern = 16'($urandom);
            len     = 5'($urandom_range(0, 31));
            rep     = 4'($urandom_range(0, 5));
        end
        drive_idle();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
Serial bit-pattern transmitter, the sending end of the serial sequence-detection path. It loads a programmable pattern and shifts it out MSB-first, one bit per clk, on a single-bit line. That line connects directly to the data_in of the downstream sequence checker. Supports repeat count, inter-repetition gap, and abort, so detector benches and on-chip self-test can generate overlapping and non-overlapping pattern streams.

Parameters:
PAT_W, 16, maximum pattern length in bits
LEN_W, 5, width of len port; must satisfy 2^LEN_W > PAT_W
CNT_W, 4, width of repeat count
GAP_CYC, 0, idle cycles (data_out=0, data_valid=0) inserted between repetitions; 0 = back-to-back

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request transmission; sampled only in IDLE
stop  input  1  abort current transmission
pattern  input  PAT_W  bits to send; bit [len-1] is sent first
len  input  LEN_W  pattern length in bits, 1..PAT_W
rep  input  CNT_W  repetition count; 0 = repeat until stop
data_out  output  1  serial bit, feeds detector data_in
data_valid  output  1  high while data_out carries a pattern bit
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- Reset (async, rst_n=0): state=IDLE; data_out=0, data_valid=0, busy=0, done=0; shift register, bit counter and rep counter cleared. Reset mid-transmission aborts immediately with no done pulse.
- States: IDLE, SHIFT, GAP.
- IDLE, on start=1 at edge N:
  - pattern, len and rep are latched at edge N.
  - len=0 or len>PAT_W is clamped to PAT_W.
  - Go to SHIFT; first bit (pattern[len-1]) appears on data_out with data_valid=1 after edge N, i.e. latency 1 cycle.
- SHIFT:
  - One bit per cycle, MSB-first, from the latched copy. Input changes during busy are ignored.
  - Bit counter counts len bits.
  - After the last bit of a repetition, the next state depends on whether repetitions remain:
    - Reps remaining and GAP_CYC>0: go to GAP.
    - Reps remaining and GAP_CYC=0: stay in SHIFT and reload, so the first bit of the next repetition follows the last bit with no bubble.
    - No reps remaining: go to IDLE and pulse done=1 for exactly the first IDLE cycle.
- GAP: data_out=0, data_valid=0 for exactly GAP_CYC cycles, then SHIFT with reload.
- rep=0: infinite repetition; done never pulses, and only stop or reset ends it.
- stop=1 in SHIFT or GAP: at the next edge go to IDLE, data_out=0, data_valid=0, no done pulse. stop in IDLE has no effect.
- start and stop both high in IDLE: stop wins and the block stays IDLE.
- start while busy is ignored, with no queueing.
- start in the same cycle done is high is accepted, since the state is IDLE. This gives back-to-back jobs with a 1-cycle bubble.
- Outside data_valid, data_out is held at 0.
- All outputs are registered.

Decomposition:
- Shared include seq_pkg: state encodings (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2) and the default PAT_W/LEN_W constants. The existing checker's pattern constant also moves here so generator and checker agree on the target sequence.
- One sub-module, seq_gen_shreg: loadable PAT_W-bit left shift register with length-aligned MSB tap. It has load and shift enables and output msb = reg[len-1] after alignment.
- The FSM, bit counter, rep counter and gap counter stay in seq_gen.

Test Plan:
- Reset sequence:
  - rst_n low 20 ns, then high → all outputs 0.
  - Assert rst_n low mid-SHIFT → outputs 0 within the same cycle, no done pulse.
- Single shot: pattern=16'h000B, len=4, rep=1, one-cycle start → data_out 1,0,1,1 on cycles 1–4 with data_valid=1, done pulse on cycle 5, busy high cycles 1–4.
- Back-to-back repeat, GAP_CYC=0: pattern=4'b1011, rep=2 → 1,0,1,1,1,0,1,1 contiguous with data_valid=1, done on cycle 9. Looping data_out into seq_check asserts flag at both pattern ends.
- Gap and clamp:
  - GAP_CYC=2, len=3, pattern=3'b110, rep=3 → 110 00 110 00 110, done once.
  - len=0 → transmits PAT_W bits.
- Abort and simultaneity:
  - rep=0, assert stop after 6 bits → IDLE next edge, data_valid=0, no done.
  - start+stop together in IDLE → stays IDLE.
  - start while busy → ignored, and the stream is unchanged.
- Restart on done: assert start in the done cycle → new stream's first bit appears the next cycle.
